// File: rtl/pipeline_mem_arbiter.sv
// Purpose : shares one single-ported memory between instruction fetch and the ld/st stage, routing read data back by tag.
// Latency : grant is combinational in the request cycle; read data returns exactly READ_LAT cycles after the grant.
// Backpressure: a denied requester holds its level request and sees stall_if/stall_mem; data wins unless fetch has starved.
//
// Ports:
//   clk, reset                         clock; asynchronous active-high reset
//   if_req/if_addr -> if_gnt           fetch read request and same-cycle accept
//   if_rvalid/if_rdata                 instruction word return
//   d_req/d_we/d_addr/d_wdata -> d_gnt data load/store request and same-cycle accept
//   d_rvalid/d_rdata                   load data return (stores return nothing)
//   mem_addr/mem_wdata/mem_we/mem_re   memory command for the granted requester
//   mem_rdata                          memory read data, valid READ_LAT cycles after mem_re
//   stall_if/stall_mem                 requester denied this cycle
module pipeline_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int READ_LAT   = 1,
   parameter int MAX_STARVE = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int               CNT_W      = $clog2(MAX_STARVE + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(MAX_STARVE);

   logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
   // Tag pipeline: one slot per cycle of memory latency; the oldest slot lines up with mem_rdata.
   logic [READ_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [READ_LAT-1:0] tag_data_q, tag_data_d;

   logic gnt_if;
   logic gnt_d;
   logic push_rd;
   logic ret_vld;
   logic ret_is_data;

   // Grants are forced low while reset is held so every output reads 0 during reset.
   always_comb begin
      gnt_if = 1'b0;
      gnt_d  = 1'b0;
      if (!reset) begin
         if (if_req && (!d_req || (starve_cnt_q >= STARVE_LIM))) begin
            gnt_if = 1'b1;
         end else if (d_req) begin
            gnt_d = 1'b1;
         end
      end
   end

   assign push_rd = gnt_if || (gnt_d && !d_we);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req || gnt_if) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_LIM) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      tag_vld_d     = '0;
      tag_data_d    = '0;
      tag_vld_d[0]  = push_rd;
      tag_data_d[0] = gnt_d;
      for (int i = 1; i < READ_LAT; i++) begin
         tag_vld_d[i]  = tag_vld_q[i-1];
         tag_data_d[i] = tag_data_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_q <= '0;
         tag_vld_q    <= '0;
         tag_data_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         tag_vld_q    <= tag_vld_d;
         tag_data_q   <= tag_data_d;
      end
   end

   assign ret_vld     = tag_vld_q[READ_LAT-1] && !reset;
   assign ret_is_data = tag_data_q[READ_LAT-1];

   always_comb begin
      if_gnt    = gnt_if;
      d_gnt     = gnt_d;
      mem_re    = push_rd;
      mem_we    = gnt_d && d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_if) begin
         mem_addr = if_addr;
      end else if (gnt_d) begin
         mem_addr = d_addr;
         if (d_we) begin
            mem_wdata = d_wdata;
         end
      end
      if_rvalid = ret_vld && !ret_is_data;
      d_rvalid  = ret_vld && ret_is_data;
      if_rdata  = if_rvalid ? mem_rdata : '0;
      d_rdata   = d_rvalid ? mem_rdata : '0;
      stall_if  = if_req && !gnt_if && !reset;
      stall_mem = d_req && !gnt_d && !reset;
   end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Purpose : checks pipeline_mem_arbiter at READ_LAT=1 and READ_LAT=3 with directed vectors and random traffic.
// Latency : outputs sampled 2-3 time units after the falling edge, inputs driven on the falling edge.
// Backpressure: the reference model tracks starvation and expected returns per absolute cycle number.
module tb_pipeline_mem_arbiter;

   localparam int MAX_ST = 3;

   typedef struct packed {
      logic        if_gnt;
      logic        d_gnt;
      logic        mem_re;
      logic        mem_we;
      logic [15:0] mem_addr;
      logic [15:0] mem_wdata;
      logic        if_rvalid;
      logic [15:0] if_rdata;
      logic        d_rvalid;
      logic [15:0] d_rdata;
      logic        stall_if;
      logic        stall_mem;
   } out_t;

   typedef struct {
      logic        if_req;
      logic [15:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      logic [15:0] rdata;
      out_t        exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic if_req, d_req, d_we;
   logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;

   logic o1_if_gnt, o1_if_rvalid, o1_d_gnt, o1_d_rvalid, o1_mem_we, o1_mem_re, o1_stall_if, o1_stall_mem;
   logic [15:0] o1_if_rdata, o1_d_rdata, o1_mem_addr, o1_mem_wdata;
   logic o3_if_gnt, o3_if_rvalid, o3_d_gnt, o3_d_rvalid, o3_mem_we, o3_mem_re, o3_stall_if, o3_stall_mem;
   logic [15:0] o3_if_rdata, o3_d_rdata, o3_mem_addr, o3_mem_wdata;

   out_t a1, a3;
   assign a1 = {o1_if_gnt, o1_d_gnt, o1_mem_re, o1_mem_we, o1_mem_addr, o1_mem_wdata,
                o1_if_rvalid, o1_if_rdata, o1_d_rvalid, o1_d_rdata, o1_stall_if, o1_stall_mem};
   assign a3 = {o3_if_gnt, o3_d_gnt, o3_mem_re, o3_mem_we, o3_mem_addr, o3_mem_wdata,
                o3_if_rvalid, o3_if_rdata, o3_d_rvalid, o3_d_rdata, o3_stall_if, o3_stall_mem};

   always #5 clk = ~clk;

   pipeline_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1), .MAX_STARVE(MAX_ST)) u_dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(o1_if_gnt), .if_rvalid(o1_if_rvalid), .if_rdata(o1_if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(o1_d_gnt), .d_rvalid(o1_d_rvalid), .d_rdata(o1_d_rdata),
      .mem_addr(o1_mem_addr), .mem_wdata(o1_mem_wdata), .mem_we(o1_mem_we), .mem_re(o1_mem_re),
      .mem_rdata(mem_rdata), .stall_if(o1_stall_if), .stall_mem(o1_stall_mem));

   pipeline_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3), .MAX_STARVE(MAX_ST)) u_dut3 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(o3_if_gnt), .if_rvalid(o3_if_rvalid), .if_rdata(o3_if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(o3_d_gnt), .d_rvalid(o3_d_rvalid), .d_rdata(o3_d_rdata),
      .mem_addr(o3_mem_addr), .mem_wdata(o3_mem_wdata), .mem_we(o3_mem_we), .mem_re(o3_mem_re),
      .mem_rdata(mem_rdata), .stall_if(o3_stall_if), .stall_mem(o3_stall_mem));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input out_t act, input out_t exp);
      chk({tag, ".if_gnt"},    16'(act.if_gnt),    16'(exp.if_gnt));
      chk({tag, ".d_gnt"},     16'(act.d_gnt),     16'(exp.d_gnt));
      chk({tag, ".mem_re"},    16'(act.mem_re),    16'(exp.mem_re));
      chk({tag, ".mem_we"},    16'(act.mem_we),    16'(exp.mem_we));
      chk({tag, ".mem_addr"},  act.mem_addr,       exp.mem_addr);
      if (exp.mem_we) chk({tag, ".mem_wdata"}, act.mem_wdata, exp.mem_wdata);
      chk({tag, ".if_rvalid"}, 16'(act.if_rvalid), 16'(exp.if_rvalid));
      chk({tag, ".if_rdata"},  act.if_rdata,       exp.if_rdata);
      chk({tag, ".d_rvalid"},  16'(act.d_rvalid),  16'(exp.d_rvalid));
      chk({tag, ".d_rdata"},   act.d_rdata,        exp.d_rdata);
      chk({tag, ".stall_if"},  16'(act.stall_if),  16'(exp.stall_if));
      chk({tag, ".stall_mem"}, 16'(act.stall_mem), 16'(exp.stall_mem));
   endtask

   // Reference model: grant from the priority rule, and a calendar of expected returns
   // indexed by the absolute cycle in which each read's data must appear.
   int         m_cyc = 0;
   int         m_starve = 0;
   logic [1:0] sched1 [16];   // bit0 = fetch return due, bit1 = load return due
   logic [1:0] sched3 [16];
   logic       m_gi, m_gd;
   logic       mon_en = 1'b0;

   assign m_gi = if_req && (!d_req || (m_starve >= MAX_ST));
   assign m_gd = d_req && !m_gi;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_starve <= 0;
         for (int i = 0; i < 16; i++) begin
            sched1[i] <= 2'b00;
            sched3[i] <= 2'b00;
         end
      end else begin
         sched1[m_cyc % 16] <= 2'b00;
         sched3[m_cyc % 16] <= 2'b00;
         if (m_gi) begin
            sched1[(m_cyc + 1) % 16] <= 2'b01;
            sched3[(m_cyc + 3) % 16] <= 2'b01;
         end else if (m_gd && !d_we) begin
            sched1[(m_cyc + 1) % 16] <= 2'b10;
            sched3[(m_cyc + 3) % 16] <= 2'b10;
         end
         if (if_req && !m_gi) m_starve <= (m_starve < MAX_ST) ? m_starve + 1 : MAX_ST;
         else                 m_starve <= 0;
      end
   end

   always @(posedge clk) m_cyc <= m_cyc + 1;

   function automatic out_t model_exp(input int lat);
      out_t       e;
      logic [1:0] s;
      e = '0;
      if (reset) return e;
      e.if_gnt    = m_gi;
      e.d_gnt     = m_gd;
      e.mem_re    = m_gi || (m_gd && !d_we);
      e.mem_we    = m_gd && d_we;
      e.mem_addr  = m_gi ? if_addr : (m_gd ? d_addr : 16'h0000);
      e.mem_wdata = d_wdata;
      s = (lat == 1) ? sched1[m_cyc % 16] : sched3[m_cyc % 16];
      e.if_rvalid = s[0];
      e.if_rdata  = s[0] ? mem_rdata : 16'h0000;
      e.d_rvalid  = s[1];
      e.d_rdata   = s[1] ? mem_rdata : 16'h0000;
      e.stall_if  = if_req && !m_gi;
      e.stall_mem = d_req && !m_gd;
      return e;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (mon_en) begin
            check_outs("model_lat1", a1, model_exp(1));
            check_outs("model_lat3", a3, model_exp(3));
         end
      end
   end

   vec_t vecs[$];

   task automatic add(input logic ireq, input logic [15:0] iaddr, input logic dreq, input logic dwe,
                      input logic [15:0] daddr, input logic [15:0] dwd, input logic [15:0] rd,
                      input logic ig, input logic dg, input logic re, input logic we, input logic [15:0] maddr,
                      input logic irv, input logic [15:0] ird, input logic drv, input logic [15:0] drd,
                      input logic sif, input logic sm);
      vec_t v;
      v.if_req = ireq; v.if_addr = iaddr; v.d_req = dreq; v.d_we = dwe;
      v.d_addr = daddr; v.d_wdata = dwd; v.rdata = rd;
      v.exp = {ig, dg, re, we, maddr, (we ? dwd : 16'h0000), irv, ird, drv, drd, sif, sm};
      vecs.push_back(v);
   endtask

   task automatic idle();
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      mem_rdata = 16'h0000;

      // Fetch-only back-to-back, then drain.
      add(1, 16'h0010, 0, 0, 16'h0, 16'h0, 16'h0000, 1, 0, 1, 0, 16'h0010, 0, 16'h0000, 0, 16'h0, 0, 0);
      add(1, 16'h0012, 0, 0, 16'h0, 16'h0, 16'hA5A5, 1, 0, 1, 0, 16'h0012, 1, 16'hA5A5, 0, 16'h0, 0, 0);
      add(0, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h5A5A, 0, 0, 0, 0, 16'h0000, 1, 16'h5A5A, 0, 16'h0, 0, 0);
      // Store beats fetch; store produces no return.
      add(1, 16'h0014, 1, 1, 16'h0100, 16'h1234, 16'h0000, 0, 1, 0, 1, 16'h0100, 0, 16'h0000, 0, 16'h0, 1, 0);
      add(0, 16'h0000, 0, 0, 16'h0, 16'h0, 16'h1111, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0, 0, 0);
      // Starvation: both held 7 cycles; fetch wins in cycle 3 only.
      add(1, 16'h0020, 1, 0, 16'h0200, 16'h0, 16'hC000, 0, 1, 1, 0, 16'h0200, 0, 16'h0000, 0, 16'h0000, 1, 0);
      add(1, 16'h0020, 1, 0, 16'h0200, 16'h0, 16'hC001, 0, 1, 1, 0, 16'h0200, 0, 16'h0000, 1, 16'hC001, 1, 0);
      add(1, 16'h0020, 1, 0, 16'h0200, 16'h0, 16'hC002, 0, 1, 1, 0, 16'h0200, 0, 16'h0000, 1, 16'hC002, 1, 0);
      add(1, 16'h0020, 1, 0, 16'h0200, 16'h0, 16'hC003, 1, 0, 1, 0, 16'h0020, 0, 16'h0000, 1, 16'hC003, 0, 1);
      add(1, 16'h0020, 1, 0, 16'h0200, 16'h0, 16'hC004, 0, 1, 1, 0, 16'h0200, 1, 16'hC004, 0, 16'h0000, 1, 0);
      add(1, 16'h0020, 1, 0, 16'h0200, 16'h0, 16'hC005, 0, 1, 1, 0, 16'h0200, 0, 16'h0000, 1, 16'hC005, 1, 0);
      add(1, 16'h0020, 1, 0, 16'h0200, 16'h0, 16'hC006, 0, 1, 1, 0, 16'h0200, 0, 16'h0000, 1, 16'hC006, 1, 0);
      add(0, 16'h0000, 0, 0, 16'h0, 16'h0, 16'hC007, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hC007, 0, 0);

      repeat (3) @(negedge clk);
      if_req = 1; d_req = 1; d_addr = 16'h0042;
      #2;
      check_outs("in_reset_lat1", a1, out_t'(0));
      check_outs("in_reset_lat3", a3, out_t'(0));
      @(negedge clk);
      idle();
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
         d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
         mem_rdata = vecs[i].rdata;
         #2;
         check_outs($sformatf("vec%0d", i), a1, vecs[i].exp);
         @(negedge clk);
      end
      idle();
      repeat (4) @(negedge clk);

      // Tag routing at READ_LAT=3: load then fetch back-to-back.
      for (int k = 0; k < 6; k++) begin
         idle();
         if (k == 0) begin d_req = 1; d_addr = 16'h0200; end
         if (k == 1) begin if_req = 1; if_addr = 16'h0004; end
         mem_rdata = 16'hB000 + 16'(k);
         #2;
         chk($sformatf("tag_d_rvalid_k%0d", k),  16'(o3_d_rvalid),  (k == 3) ? 16'h1 : 16'h0);
         chk($sformatf("tag_d_rdata_k%0d", k),   o3_d_rdata,        (k == 3) ? 16'hB003 : 16'h0);
         chk($sformatf("tag_if_rvalid_k%0d", k), 16'(o3_if_rvalid), (k == 4) ? 16'h1 : 16'h0);
         chk($sformatf("tag_if_rdata_k%0d", k),  o3_if_rdata,       (k == 4) ? 16'hB004 : 16'h0);
         @(negedge clk);
      end

      // Reset with reads in flight: nothing issued before reset may return.
      idle(); d_req = 1; d_addr = 16'h0300; mem_rdata = 16'h7777;
      @(negedge clk);
      idle(); if_req = 1; if_addr = 16'h0006;
      @(negedge clk);
      reset = 1'b1;
      #2;
      check_outs("mid_reset_lat1", a1, out_t'(0));
      check_outs("mid_reset_lat3", a3, out_t'(0));
      @(negedge clk);
      idle();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #2;
         chk($sformatf("post_reset_rv3_%0d", k), {14'h0, o3_if_rvalid, o3_d_rvalid}, 16'h0);
         chk($sformatf("post_reset_rv1_%0d", k), {14'h0, o1_if_rvalid, o1_d_rvalid}, 16'h0);
         @(negedge clk);
      end

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         reset   = ($urandom_range(0, 99) == 0);
         if_req  = ($urandom_range(0, 2) != 0);
         d_req   = ($urandom_range(0, 1) != 0);
         d_we    = ($urandom_range(0, 2) == 0);
         if_addr = 16'($urandom);
         d_addr  = 16'($urandom);
         d_wdata = 16'($urandom);
         mem_rdata = 16'($urandom);
         @(negedge clk);
      end
      reset = 1'b0;
      idle();
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
